// File: rtl/mcp_rx_arbiter_if.sv
// Signal bundle between mcp_rx_arbiter, its uart_rx channels and the packet consumer.
// The master modport is the arbiter side. The slave modport is the channel/consumer side.
interface mcp_rx_arbiter_if #(
    parameter int WIDTH        = 64,
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 16
);
    localparam int PKT_W = WIDTH - 1;
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CHANNELS-1:0]       rx_empty;
    logic [NUM_CHANNELS*PKT_W-1:0] rx_data;
    logic [NUM_CHANNELS-1:0]       parity_error;
    logic [NUM_CHANNELS-1:0]       uld_rx_data;
    logic                          pkt_valid;
    logic                          pkt_ready;
    logic [PKT_W-1:0]              pkt_data;
    logic [CH_W-1:0]               pkt_channel;
    logic                          pkt_parity_err;
    logic [1:0]                    pkt_type;
    logic [7:0]                    pkt_chip_id;
    logic [CNT_W-1:0]              fifo_count;
    logic                          stuck_flag;
    logic [63:0]                   stat_type_cnt;
    logic [15:0]                   stat_parity_cnt;

    modport master (
        input  rx_empty, rx_data, parity_error, pkt_ready,
        output uld_rx_data, pkt_valid, pkt_data, pkt_channel, pkt_parity_err,
               pkt_type, pkt_chip_id, fifo_count, stuck_flag, stat_type_cnt, stat_parity_cnt
    );

    modport slave (
        output rx_empty, rx_data, parity_error, pkt_ready,
        input  uld_rx_data, pkt_valid, pkt_data, pkt_channel, pkt_parity_err,
               pkt_type, pkt_chip_id, fifo_count, stuck_flag, stat_type_cnt, stat_parity_cnt
    );
endinterface

// File: rtl/mcp_rx_arbiter.sv
// Round-robin drain of NUM_CHANNELS uart_rx channels into a shared FWFT packet FIFO.
// Defining MCP_RX_STATS_EN enables the per-type and parity packet counters; otherwise they read 0.
module mcp_rx_arbiter #(
    parameter int WIDTH           = 64,
    parameter int NUM_CHANNELS    = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int RELEASE_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    mcp_rx_arbiter_if.master bus
);
    localparam int PKT_W = WIDTH - 1;
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = CH_W + 1 + PKT_W;
    localparam int TMR_W = (RELEASE_TIMEOUT > 1) ? $clog2(RELEASE_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        UNLOAD  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [CH_W-1:0]         sel_reg, sel_next;
    logic [CH_W-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [TMR_W-1:0]        timer_reg, timer_next;
    logic                    stuck_reg, stuck_next;
    logic [NUM_CHANNELS-1:0] uld_reg, uld_next;

    logic [PKT_W-1:0]        ch_data [NUM_CHANNELS];
    logic                    pick_found;
    logic [CH_W-1:0]         pick_ch;
    int                      scan_idx;

    logic [ENT_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    fifo_valid;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic [ENT_W-1:0]        push_entry;
    logic [ENT_W-1:0]        head_entry;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch_slice
            assign ch_data[gi] = bus.rx_data[gi*PKT_W +: PKT_W];
        end
    endgenerate

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        if (int'(c) >= NUM_CHANNELS - 1) begin
            return '0;
        end
        return c + CH_W'(1);
    endfunction

    // First pending channel at or after rr_ptr, wrapping around the channel set.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr_ptr_reg;
        scan_idx   = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            scan_idx = int'(rr_ptr_reg) + i;
            if (scan_idx >= NUM_CHANNELS) begin
                scan_idx = scan_idx - NUM_CHANNELS;
            end
            if (!pick_found && !bus.rx_empty[scan_idx]) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            rr_ptr_reg <= '0;
            timer_reg  <= '0;
            stuck_reg  <= 1'b0;
            uld_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
            timer_reg  <= timer_next;
            stuck_reg  <= stuck_next;
            uld_reg    <= uld_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        timer_next  = timer_reg;
        stuck_next  = stuck_reg;
        uld_next    = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_full && pick_found) begin
                    sel_next   = pick_ch;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                // Registered strobe: high for exactly the UNLOAD cycle.
                uld_next   = NUM_CHANNELS'(1) << sel_reg;
                state_next = UNLOAD;
            end
            UNLOAD: begin
                timer_next = '0;
                state_next = RELEASE;
            end
            RELEASE: begin
                if (bus.rx_empty[sel_reg]) begin
                    rr_ptr_next = next_ch(sel_reg);
                    state_next  = IDLE;
                end else if (timer_reg == TMR_W'(RELEASE_TIMEOUT - 1)) begin
                    // Channel never cleared: flag it and move on so others are not starved.
                    stuck_next  = 1'b1;
                    rr_ptr_next = next_ch(sel_reg);
                    state_next  = IDLE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign push       = (state_reg == CAPTURE);
    assign fifo_valid = (count_reg != '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop        = fifo_valid && bus.pkt_ready;
    assign push_entry = {sel_reg, bus.parity_error[sel_reg], ch_data[sel_reg]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign head_entry         = fifo_valid ? mem[rd_ptr_reg] : '0;
    assign bus.pkt_valid      = fifo_valid;
    assign bus.pkt_data       = head_entry[PKT_W-1:0];
    assign bus.pkt_parity_err = head_entry[PKT_W];
    assign bus.pkt_channel    = head_entry[ENT_W-1 -: CH_W];
    assign bus.pkt_type       = head_entry[1:0];
    assign bus.pkt_chip_id    = head_entry[9:2];
    assign bus.fifo_count     = count_reg;
    assign bus.stuck_flag     = stuck_reg;
    assign bus.uld_rx_data    = uld_reg;

`ifdef MCP_RX_STATS_EN
    logic [1:0]  cap_type;
    logic [15:0] type_cnt_reg [4];
    logic [15:0] parity_cnt_reg;

    assign cap_type = ch_data[sel_reg][1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < 4; t++) begin
                type_cnt_reg[t] <= '0;
            end
            parity_cnt_reg <= '0;
        end else if (push) begin
            for (int t = 0; t < 4; t++) begin
                if (cap_type == 2'(t) && type_cnt_reg[t] != 16'hFFFF) begin
                    type_cnt_reg[t] <= type_cnt_reg[t] + 16'd1;
                end
            end
            if (bus.parity_error[sel_reg] && parity_cnt_reg != 16'hFFFF) begin
                parity_cnt_reg <= parity_cnt_reg + 16'd1;
            end
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_stat_out
            assign bus.stat_type_cnt[16*gi +: 16] = type_cnt_reg[gi];
        end
    endgenerate
    assign bus.stat_parity_cnt = parity_cnt_reg;
`else
    assign bus.stat_type_cnt   = '0;
    assign bus.stat_parity_cnt = '0;
`endif

endmodule

// File: tb/tb_mcp_rx_arbiter.sv
// Bench for mcp_rx_arbiter: channel models plus a queue-based scoreboard and round-robin predictor.
// Honours MCP_RX_STATS_EN when predicting the statistics counters.
module tb_mcp_rx_arbiter;
    localparam int WIDTH = 64;
    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 15;
    localparam int PW    = WIDTH - 1;
`ifdef MCP_RX_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]    ch;
        logic          par;
        logic [PW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mcp_rx_arbiter_if #(.WIDTH(WIDTH), .NUM_CHANNELS(N), .FIFO_DEPTH(DEPTH)) bus ();

    mcp_rx_arbiter #(
        .WIDTH(WIDTH), .NUM_CHANNELS(N), .FIFO_DEPTH(DEPTH), .RELEASE_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int            checks = 0;
    int            passes = 0;
    int            fails  = 0;
    ent_t          exp_q[$];
    int            served[$];
    logic [PW-1:0] ch_pkt [N];
    logic          ch_par [N];
    bit            ch_full [N];
    bit            ch_hold [N];
    int            ch_cool [N];
    int            hold_age [N];
    bit [N-1:0]    refill_mask;
    bit            rand_ready;
    logic [N-1:0]  snap_cur, snap_prev, uld_prev;
    logic          rdy_edge;
    int            rr_m;
    bit            exp_stuck;
    int            type_m [4];
    int            par_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat16(input int v);
        return (v > 65535) ? 64'd65535 : 64'(v);
    endfunction

    function automatic logic [PW-1:0] rand_pkt(input logic [1:0] typ);
        logic [PW-1:0] p;
        p      = PW'({$urandom(), $urandom()});
        p[1:0] = typ;
        return p;
    endfunction

    // Expected grant: first pending channel scanning from the pointer after the last one served.
    function automatic int arb_expect(input logic [N-1:0] pend, input int rr);
        for (int i = 0; i < N; i++) begin
            if (pend[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_channels();
        for (int c = 0; c < N; c++) begin
            bus.rx_empty[c]            = !ch_full[c];
            bus.rx_data[c*PW +: PW]    = ch_pkt[c];
            bus.parity_error[c]        = ch_par[c];
        end
    endtask

    task automatic load_ch(input int c, input logic [PW-1:0] p, input logic par);
        ch_pkt[c]  = p;
        ch_par[c]  = par;
        ch_full[c] = 1'b1;
        drive_channels();
    endtask

    task automatic clear_model();
        exp_q.delete();
        rr_m      = 0;
        exp_stuck = 1'b0;
        par_m     = 0;
        uld_prev  = '0;
        for (int t = 0; t < 4; t++) type_m[t] = 0;
        for (int c = 0; c < N; c++) begin
            ch_full[c]  = 1'b0;
            ch_hold[c]  = 1'b0;
            ch_par[c]   = 1'b0;
            ch_cool[c]  = 0;
            hold_age[c] = -1;
        end
        drive_channels();
    endtask

    task automatic step();
        logic [N-1:0] u;
        int           c;
        ent_t         e;
        snap_prev = snap_cur;
        snap_cur  = ~bus.rx_empty;
        rdy_edge  = bus.pkt_ready;
        @(posedge clk);
        #1;
        if (rdy_edge && exp_q.size() > 0) exp_q.delete(0);
        for (int k = 0; k < N; k++) begin
            if (hold_age[k] >= 0) begin
                hold_age[k]++;
                if (hold_age[k] == TMO + 1) begin
                    exp_stuck   = 1'b1;
                    ch_hold[k]  = 1'b0;
                    ch_full[k]  = 1'b0;
                    ch_cool[k]  = 2;
                    hold_age[k] = -1;
                end
            end
        end
        u = bus.uld_rx_data;
        if (uld_prev != '0) chk("uld_single_cycle", 64'(u), 64'd0);
        if (u != '0) begin
            chk("uld_onehot", 64'($countones(u)), 64'd1);
            c = 0;
            for (int k = 0; k < N; k++) if (u[k]) c = k;
            chk("arb_channel", 64'(c), 64'(arb_expect(snap_prev, rr_m)));
            served.push_back(c);
            e.ch   = 2'(c);
            e.par  = ch_par[c];
            e.data = ch_pkt[c];
            exp_q.push_back(e);
            type_m[ch_pkt[c][1:0]]++;
            if (ch_par[c]) par_m++;
            chk("fifo_no_overflow", 64'(exp_q.size() <= DEPTH), 64'd1);
            rr_m = (c + 1) % N;
            if (ch_hold[c]) begin
                hold_age[c] = 0;
            end else begin
                ch_full[c] = 1'b0;
                ch_cool[c] = 2;
            end
        end
        uld_prev = u;
        chk("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
        chk("pkt_valid", 64'(bus.pkt_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() > 0) begin
            chk("pkt_data", 64'(bus.pkt_data), 64'(exp_q[0].data));
            chk("pkt_channel", 64'(bus.pkt_channel), 64'(exp_q[0].ch));
            chk("pkt_parity_err", 64'(bus.pkt_parity_err), 64'(exp_q[0].par));
            chk("pkt_type", 64'(bus.pkt_type), 64'(exp_q[0].data[1:0]));
            chk("pkt_chip_id", 64'(bus.pkt_chip_id), 64'(exp_q[0].data[9:2]));
        end
        chk("stuck_flag", 64'(bus.stuck_flag), 64'(exp_stuck));
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("stat_type%0d", t), 64'(bus.stat_type_cnt[16*t +: 16]),
                STATS_EN ? sat16(type_m[t]) : 64'd0);
        end
        chk("stat_parity", 64'(bus.stat_parity_cnt), STATS_EN ? sat16(par_m) : 64'd0);
        for (int k = 0; k < N; k++) begin
            if (ch_cool[k] > 0) begin
                ch_cool[k]--;
            end else if (!ch_full[k] && refill_mask[k] && $urandom_range(0, 1) == 0) begin
                ch_pkt[k]  = rand_pkt(2'($urandom_range(0, 3)));
                ch_par[k]  = ($urandom_range(0, 7) == 0);
                ch_full[k] = 1'b1;
            end
        end
        if (rand_ready) bus.pkt_ready = ($urandom_range(0, 3) != 0);
        drive_channels();
    endtask

    function automatic bit any_pending();
        for (int c = 0; c < N; c++) if (ch_full[c]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        refill_mask   = '0;
        rand_ready    = 1'b0;
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || any_pending()); i++) step();
        repeat (4) step();
        chk("drain_fifo_count", 64'(bus.fifo_count), 64'd0);
    endtask

    task automatic wait_served(input int n, input string tag);
        for (int i = 0; i < 40 && served.size() < n; i++) step();
        chk(tag, 64'(served.size()), 64'(n));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        int exp_order [4];
        exp_order     = '{2, 3, 0, 1};
        reset         = 1'b1;
        bus.pkt_ready = 1'b0;
        refill_mask   = '0;
        rand_ready    = 1'b0;
        snap_cur      = '0;
        snap_prev     = '0;
        for (int c = 0; c < N; c++) ch_pkt[c] = '0;
        clear_model();
        repeat (3) step();
        chk("reset_uld", 64'(bus.uld_rx_data), 64'd0);
        chk("reset_valid", 64'(bus.pkt_valid), 64'd0);
        chk("reset_count", 64'(bus.fifo_count), 64'd0);
        chk("reset_data", 64'(bus.pkt_data), 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // Single type-2 packet on ch0: valid two cycles after rx_empty falls.
        bus.pkt_ready = 1'b1;
        begin
            logic [PW-1:0] p;
            p      = rand_pkt(2'd2);
            p[9:2] = 8'h0A;
            load_ch(0, p, 1'b0);
        end
        step();
        chk("t1_valid_after_1", 64'(bus.pkt_valid), 64'd0);
        step();
        chk("t1_valid_after_2", 64'(bus.pkt_valid), 64'd1);
        chk("t1_type", 64'(bus.pkt_type), 64'd2);
        chk("t1_chip_id", 64'(bus.pkt_chip_id), 64'h0A);
        chk("t1_channel", 64'(bus.pkt_channel), 64'd0);
        chk("t1_uld", 64'(bus.uld_rx_data), 64'b0001);
        step();
        chk("t1_uld_drop", 64'(bus.uld_rx_data), 64'd0);
        repeat (4) step();

        // Serve ch1 so the pointer sits at 2, then load all four at once.
        load_ch(1, rand_pkt(2'd1), 1'b0);
        repeat (8) step();
        bus.pkt_ready = 1'b0;
        served.delete();
        for (int c = 0; c < N; c++) load_ch(c, rand_pkt(2'd0), 1'b0);
        wait_served(4, "t2_served_count");
        for (int i = 0; i < 4; i++) chk($sformatf("t2_order%0d", i), 64'(served[i]), 64'(exp_order[i]));
        drain();

        // Parity error on ch2 with a type-3 packet.
        bus.pkt_ready = 1'b0;
        n0 = served.size();
        load_ch(2, rand_pkt(2'd3), 1'b1);
        wait_served(n0 + 1, "t5_served");
        chk("t5_parity_err", 64'(bus.pkt_parity_err), 64'd1);
        chk("t5_type", 64'(bus.pkt_type), 64'd3);
        chk("t5_stat_type3", 64'(bus.stat_type_cnt[63:48]), STATS_EN ? 64'd1 : 64'd0);
        chk("t5_stat_parity", 64'(bus.stat_parity_cnt), STATS_EN ? 64'd1 : 64'd0);
        drain();

        // Backpressure: ch1 refilled continuously with the consumer stalled.
        bus.pkt_ready = 1'b0;
        n0            = served.size();
        refill_mask   = 4'b0010;
        for (int i = 0; i < 300 && exp_q.size() < DEPTH; i++) step();
        chk("t3_full_count", 64'(bus.fifo_count), 64'(DEPTH));
        repeat (12) step();
        chk("t3_accepted", 64'(served.size() - n0), 64'(DEPTH));
        bus.pkt_ready = 1'b1;
        step();
        bus.pkt_ready = 1'b0;
        chk("t3_after_pop", 64'(bus.fifo_count), 64'(DEPTH - 1));
        wait_served(n0 + DEPTH + 1, "t3_next_capture");
        drain();

        // Random traffic on all channels with random consumer stalls (push/pop overlap, wrap).
        refill_mask = '1;
        rand_ready  = 1'b1;
        repeat (1500) step();
        drain();

        // Channel 0 never releases: timeout, then ch1 is next.
        ch_hold[0] = 1'b1;
        n0 = served.size();
        load_ch(0, rand_pkt(2'd0), 1'b0);
        wait_served(n0 + 1, "t6_ch0_served");
        chk("t6_first_ch", 64'(served[served.size()-1]), 64'd0);
        load_ch(1, rand_pkt(2'd1), 1'b0);
        for (int i = 0; i < 30 && !exp_stuck; i++) step();
        chk("t6_stuck_flag", 64'(bus.stuck_flag), 64'd1);
        wait_served(n0 + 2, "t6_next_served");
        chk("t6_next_ch", 64'(served[served.size()-1]), 64'd1);
        drain();

        // Reset while the unload strobe is high.
        n0 = served.size();
        load_ch(3, rand_pkt(2'd1), 1'b0);
        wait_served(n0 + 1, "t6_unload_reached");
        chk("t6_pre_reset_uld", 64'(bus.uld_rx_data), 64'b1000);
        reset = 1'b1;
        #1;
        chk("t6_reset_uld", 64'(bus.uld_rx_data), 64'd0);
        chk("t6_reset_count", 64'(bus.fifo_count), 64'd0);
        chk("t6_reset_valid", 64'(bus.pkt_valid), 64'd0);
        chk("t6_reset_stuck", 64'(bus.stuck_flag), 64'd0);
        clear_model();
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        chk("t6_post_reset_count", 64'(bus.fifo_count), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
